// File: rtl/exe_pkg.sv
// exe_pkg -- shared definitions for the execute stage.
//
// Holds the exec_cmd encodings produced by decode and consumed by the
// ALU, the bit positions of the NZCV flags inside the 4-bit status word,
// and a small classifier that groups commands by how they update flags.
// The decode stage imports this same package so both sides agree on the
// encodings.
//
// Contents:
//   EXE_* command codes      4-bit exec_cmd values
//   FLAG_N/Z/C/V             bit index of each flag in status (N = bit 3)
//   alu_class_e, cmd_class() flag-update class of a command
package exe_pkg;

  // ALU command encodings (exec_cmd).
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;

  // Bit positions inside status = {N, Z, C, V}.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // How a command treats the C and V flags.
  //   ALU_CLASS_LOGIC : MOV/MVN/AND/ORR/EOR, C and V pass through
  //   ALU_CLASS_ADD   : ADD/ADC, C = carry-out
  //   ALU_CLASS_SUB   : SUB/SBC, C = NOT borrow
  //   ALU_CLASS_ZERO  : undefined codes, result forced to 0, C/V pass through
  typedef enum logic [1:0] {
    ALU_CLASS_LOGIC = 2'd0,
    ALU_CLASS_ADD   = 2'd1,
    ALU_CLASS_SUB   = 2'd2,
    ALU_CLASS_ZERO  = 2'd3
  } alu_class_e;

  function automatic alu_class_e cmd_class(input logic [3:0] cmd);
    alu_class_e cls;
    case (cmd)
      EXE_MOV, EXE_MVN, EXE_AND, EXE_ORR, EXE_EOR: cls = ALU_CLASS_LOGIC;
      EXE_ADD, EXE_ADC:                            cls = ALU_CLASS_ADD;
      EXE_SUB, EXE_SBC:                            cls = ALU_CLASS_SUB;
      default:                                     cls = ALU_CLASS_ZERO;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/exe_stage_alu.sv
// alu -- purely combinational ALU of the execute stage.
//
// Computes the result selected by exec_cmd together with the next NZCV
// flag set. N and Z always follow the result. C is the carry-out for
// ADD/ADC and NOT borrow for SUB/SBC; every other command passes c_in
// through. V is the signed overflow of ADD/ADC/SUB/SBC when
// EXE_OVERFLOW_EN is defined; otherwise V is the constant 0 and the
// v_in port does not exist.
//
// Ports:
//   exec_cmd  in  4      command (see exe_pkg)
//   val_rn    in  WIDTH  first operand
//   val2      in  WIDTH  second operand
//   c_in      in  1      current C flag (used by ADC/SBC and pass-through)
//   v_in      in  1      current V flag (only with EXE_OVERFLOW_EN)
//   result    out WIDTH  ALU result
//   nzcv      out 4      next flags {N, Z, C, V}
module alu
  import exe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       exec_cmd,
  input  logic [WIDTH-1:0] val_rn,
  input  logic [WIDTH-1:0] val2,
  input  logic             c_in,
`ifdef EXE_OVERFLOW_EN
  input  logic             v_in,
`endif
  output logic [WIDTH-1:0] result,
  output logic [3:0]       nzcv
);

  alu_class_e       cls;
  logic [WIDTH-1:0] b_op;
  logic             carry_in;
  logic [WIDTH:0]   sum;
  logic             c_new;
  logic             v_new;

  // One shared adder serves all four arithmetic commands. Subtraction is
  // a + ~b + 1, and SBC's "- (1 - C)" folds into a + ~b + C, so the adder
  // carry-out is directly NOT borrow for the sub class.
  always_comb begin
    cls      = cmd_class(exec_cmd);
    b_op     = val2;
    carry_in = 1'b0;
    case (exec_cmd)
      EXE_ADC: carry_in = c_in;
      EXE_SUB: begin
        b_op     = ~val2;
        carry_in = 1'b1;
      end
      EXE_SBC: begin
        b_op     = ~val2;
        carry_in = c_in;
      end
      default: ;
    endcase
  end

  assign sum = {1'b0, val_rn} + {1'b0, b_op} + {{WIDTH{1'b0}}, carry_in};

  always_comb begin
    result = '0;
    case (exec_cmd)
      EXE_MOV:                            result = val2;
      EXE_MVN:                            result = ~val2;
      EXE_ADD, EXE_ADC, EXE_SUB, EXE_SBC: result = sum[WIDTH-1:0];
      EXE_AND:                            result = val_rn & val2;
      EXE_ORR:                            result = val_rn | val2;
      EXE_EOR:                            result = val_rn ^ val2;
      default:                            result = '0;
    endcase
  end

  always_comb begin
    c_new = c_in;
    if (cls == ALU_CLASS_ADD || cls == ALU_CLASS_SUB) begin
      c_new = sum[WIDTH];
    end
  end

`ifdef EXE_OVERFLOW_EN
  // Signed overflow: both adder operands share a sign and the sum's sign
  // differs from it. b_op is already inverted for subtraction.
  always_comb begin
    v_new = v_in;
    if (cls == ALU_CLASS_ADD || cls == ALU_CLASS_SUB) begin
      v_new = (val_rn[WIDTH-1] == b_op[WIDTH-1]) &&
              (sum[WIDTH-1] != val_rn[WIDTH-1]);
    end
  end
`else
  assign v_new = 1'b0;
`endif

  always_comb begin
    nzcv         = 4'b0000;
    nzcv[FLAG_N] = result[WIDTH-1];
    nzcv[FLAG_Z] = (result == '0);
    nzcv[FLAG_C] = c_new;
    nzcv[FLAG_V] = v_new;
  end

endmodule

// File: rtl/exe_stage.sv
// exe_stage -- execute stage of the pipeline.
//
// Runs the combinational ALU on the decoded operands, registers the
// result and memory/write-back controls into the EXE/MEM pipeline
// register, keeps the NZCV status register and produces the branch
// decision and target combinationally.
//
// Configuration macro: EXE_OVERFLOW_EN -- when defined the V flag tracks
// signed overflow of add/sub commands; when undefined V is constant 0.
//
// Ports:
//   clk           in   1      rising-edge clock
//   rst           in   1      synchronous active-high reset
//   stall         in   1      hold pipeline register and status
//   flush         in   1      load a bubble into the pipeline register
//   exec_cmd      in   4      ALU command
//   mem_read, mem_write, wb_enable, B, S  in 1 each  decode controls
//   val_rn, val2  in   WIDTH  operands
//   dest          in   4      destination register index
//   pc            in   WIDTH  PC + 4 of this instruction
//   imm24         in   24     branch word offset
//   alu_result_q, st_val_q  out WIDTH  registered result / store data
//   dest_q        out  4      registered destination
//   wb_en_q, mem_r_q, mem_w_q  out 1 each  registered controls
//   status        out  4      {N, Z, C, V}
//   branch_taken  out  1      B & ~flush
//   branch_addr   out  WIDTH  pc + sext(imm24) * 4
module exe_stage
  import exe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic [3:0]       exec_cmd,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             wb_enable,
  input  logic             B,
  input  logic             S,
  input  logic [WIDTH-1:0] val_rn,
  input  logic [WIDTH-1:0] val2,
  input  logic [3:0]       dest,
  input  logic [WIDTH-1:0] pc,
  input  logic [23:0]      imm24,
  output logic [WIDTH-1:0] alu_result_q,
  output logic [WIDTH-1:0] st_val_q,
  output logic [3:0]       dest_q,
  output logic             wb_en_q,
  output logic             mem_r_q,
  output logic             mem_w_q,
  output logic [3:0]       status,
  output logic             branch_taken,
  output logic [WIDTH-1:0] branch_addr
);

  logic [WIDTH-1:0]  alu_result;
  logic [3:0]        alu_nzcv;
  logic [WIDTH+25:0] offset_ext;

  alu #(.WIDTH(WIDTH)) u_alu (
    .exec_cmd (exec_cmd),
    .val_rn   (val_rn),
    .val2     (val2),
    .c_in     (status[FLAG_C]),
`ifdef EXE_OVERFLOW_EN
    .v_in     (status[FLAG_V]),
`endif
    .result   (alu_result),
    .nzcv     (alu_nzcv)
  );

  // Pipeline control: each edge applies the first of rst, flush, stall,
  // capture. flush wins over stall so a squashed instruction never sits
  // in the register while the pipeline is frozen. Status follows the
  // same order but only loads on a captured instruction with S set; a
  // flush leaves status untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_result_q <= '0;
      st_val_q     <= '0;
      dest_q       <= '0;
      wb_en_q      <= 1'b0;
      mem_r_q      <= 1'b0;
      mem_w_q      <= 1'b0;
      status       <= 4'b0000;
    end else if (flush) begin
      alu_result_q <= '0;
      st_val_q     <= '0;
      dest_q       <= '0;
      wb_en_q      <= 1'b0;
      mem_r_q      <= 1'b0;
      mem_w_q      <= 1'b0;
    end else if (!stall) begin
      alu_result_q <= alu_result;
      st_val_q     <= val_rn;
      dest_q       <= dest;
      wb_en_q      <= wb_enable;
      mem_r_q      <= mem_read;
      mem_w_q      <= mem_write;
      if (S) begin
        status <= alu_nzcv;
      end
    end
  end

  // Branch target: sign-extend the word offset, scale by 4 and wrap to
  // WIDTH bits. The extension is wide enough for any WIDTH.
  assign offset_ext   = {{WIDTH{imm24[23]}}, imm24, 2'b00};
  assign branch_addr  = pc + offset_ext[WIDTH-1:0];
  assign branch_taken = B & ~flush;

endmodule
